riscv_dm_abstract_ctrl: RTL and testbench

//  Sequences Access Register abstract commands (cmdtype 0) in the debug module. Sits between the DMI register file
//  (COMMAND/ABSTRACTCS/DATA) and the hart debug interface. Validates each command, drives the hart register-access
//  and program-buffer handshakes, and owns abstractcs.busy/cmderr and the regno post-increment.

---
 rtl/riscv_dm_abstract_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_riscv_dm_abstract_ctrl.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dm_abstract_ctrl.sv
// Access Register abstract command sequencer: validates COMMAND writes, runs the hart
// register handshake and optional program-buffer execution, and owns busy/cmderr/regno.
module riscv_dm_abstract_ctrl #(
   parameter int XLEN           = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            dmactive_i,
   input  logic            cmd_valid_i,
   input  logic [31:0]     cmd_i,
   input  logic [2:0]      cmderr_clr_i,
   input  logic            data_access_i,
   input  logic            hart_halted_i,
   input  logic [XLEN-1:0] data_i,
   output logic            reg_req_o,
   output logic            reg_we_o,
   output logic [15:0]     reg_addr_o,
   output logic [XLEN-1:0] reg_wdata_o,
   input  logic            reg_ack_i,
   input  logic            reg_err_i,
   input  logic [XLEN-1:0] reg_rdata_i,
   output logic            progbuf_req_o,
   input  logic            progbuf_done_i,
   input  logic            progbuf_exc_i,
   output logic            data_wr_o,
   output logic [XLEN-1:0] data_wdata_o,
   output logic            cmd_wr_o,
   output logic [15:0]     cmd_regno_o,
   output logic            busy_o,
   output logic [2:0]      cmderr_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, XFER, PROGBUF, FIN} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic              we_q, we_d;
   logic              size64_q, size64_d;
   logic              postinc_q, postinc_d;
   logic              postexec_q, postexec_d;
   logic [15:0]       regno_q, regno_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic              data_wr_q, data_wr_d;
   logic [XLEN-1:0]   data_wdata_q, data_wdata_d;
   logic              cmd_wr_q, cmd_wr_d;
   logic [15:0]       cmd_regno_q, cmd_regno_d;
   logic [2:0]        cmderr_q, cmderr_d;

   logic [7:0]        cmdtype;
   logic [2:0]        aarsize;
   logic              transfer;
   logic              size_ok;
   logic              tmo_expire;
   logic              err_set;
   logic [2:0]        err_code;
   logic [XLEN-1:0]   rdata_fmt;
   logic [XLEN-1:0]   wdata_fmt;
   logic              unused_cmd_bit;

   assign cmdtype        = cmd_i[31:24];
   assign aarsize        = cmd_i[22:20];
   assign transfer       = cmd_i[17];
   assign unused_cmd_bit = cmd_i[23];
   assign size_ok        = (aarsize == 3'd2) || (aarsize == 3'd3 && XLEN == 64);
   assign tmo_expire     = (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // 32-bit accesses move only the low word; the upper part is zero-extended
   always_comb begin
      rdata_fmt = reg_rdata_i;
      if (!size64_q) begin
         rdata_fmt       = '0;
         rdata_fmt[31:0] = reg_rdata_i[31:0];
      end
      wdata_fmt = data_i;
      if (aarsize != 3'd3) begin
         wdata_fmt       = '0;
         wdata_fmt[31:0] = data_i[31:0];
      end
   end

   always_comb begin
      state_d      = state_q;
      tmo_cnt_d    = tmo_cnt_q + CW'(1);
      we_d         = we_q;
      size64_d     = size64_q;
      postinc_d    = postinc_q;
      postexec_d   = postexec_q;
      regno_d      = regno_q;
      wdata_d      = wdata_q;
      data_wr_d    = 1'b0;
      data_wdata_d = data_wdata_q;
      cmd_wr_d     = 1'b0;
      cmd_regno_d  = cmd_regno_q;
      err_set      = 1'b0;
      err_code     = 3'd0;

      case (state_q)
         IDLE: begin
            tmo_cnt_d = '0;
            if (cmd_valid_i && cmderr_q == 3'd0) begin
               if (cmdtype != 8'd0 || (transfer && !size_ok) ||
                   (transfer && cmd_i[15:0] > 16'h101F)) begin
                  err_set  = 1'b1;
                  err_code = 3'd2;
               end else if (!hart_halted_i) begin
                  err_set  = 1'b1;
                  err_code = 3'd4;
               end else begin
                  we_d       = cmd_i[16];
                  size64_d   = (aarsize == 3'd3);
                  postinc_d  = cmd_i[19];
                  postexec_d = cmd_i[18];
                  regno_d    = cmd_i[15:0];
                  wdata_d    = wdata_fmt;
                  state_d    = transfer ? XFER : (cmd_i[18] ? PROGBUF : FIN);
               end
            end
         end
         XFER: begin
            // an ack arriving in the expiry cycle still completes the access
            if (reg_ack_i) begin
               tmo_cnt_d = '0;
               if (reg_err_i) begin
                  err_set  = 1'b1;
                  err_code = 3'd3;
                  state_d  = IDLE;
               end else begin
                  if (!we_q) begin
                     data_wr_d    = 1'b1;
                     data_wdata_d = rdata_fmt;
                  end
                  if (postinc_q) begin
                     cmd_wr_d    = 1'b1;
                     cmd_regno_d = regno_q + 16'd1;
                  end
                  state_d = postexec_q ? PROGBUF : IDLE;
               end
            end else if (tmo_expire) begin
               err_set  = 1'b1;
               err_code = 3'd7;
               state_d  = IDLE;
            end
         end
         PROGBUF: begin
            if (progbuf_done_i) begin
               err_set  = progbuf_exc_i;
               err_code = 3'd3;
               state_d  = IDLE;
            end else if (tmo_expire) begin
               err_set  = 1'b1;
               err_code = 3'd7;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && !err_set &&
          (cmd_valid_i || data_access_i || cmderr_clr_i != 3'd0)) begin
         err_set  = 1'b1;
         err_code = 3'd1;
      end

      cmderr_d = (err_set && cmderr_q == 3'd0) ? err_code : (cmderr_q & ~cmderr_clr_i);

      if (!dmactive_i) begin
         state_d      = IDLE;
         tmo_cnt_d    = '0;
         we_d         = 1'b0;
         size64_d     = 1'b0;
         postinc_d    = 1'b0;
         postexec_d   = 1'b0;
         regno_d      = '0;
         wdata_d      = '0;
         data_wr_d    = 1'b0;
         data_wdata_d = '0;
         cmd_wr_d     = 1'b0;
         cmd_regno_d  = '0;
         cmderr_d     = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         tmo_cnt_q    <= '0;
         we_q         <= 1'b0;
         size64_q     <= 1'b0;
         postinc_q    <= 1'b0;
         postexec_q   <= 1'b0;
         regno_q      <= '0;
         wdata_q      <= '0;
         data_wr_q    <= 1'b0;
         data_wdata_q <= '0;
         cmd_wr_q     <= 1'b0;
         cmd_regno_q  <= '0;
         cmderr_q     <= '0;
      end else begin
         state_q      <= state_d;
         tmo_cnt_q    <= tmo_cnt_d;
         we_q         <= we_d;
         size64_q     <= size64_d;
         postinc_q    <= postinc_d;
         postexec_q   <= postexec_d;
         regno_q      <= regno_d;
         wdata_q      <= wdata_d;
         data_wr_q    <= data_wr_d;
         data_wdata_q <= data_wdata_d;
         cmd_wr_q     <= cmd_wr_d;
         cmd_regno_q  <= cmd_regno_d;
         cmderr_q     <= cmderr_d;
      end
   end

   assign busy_o        = (state_q != IDLE);
   assign reg_req_o     = (state_q == XFER);
   assign reg_we_o      = reg_req_o & we_q;
   assign reg_addr_o    = reg_req_o ? regno_q : 16'd0;
   assign reg_wdata_o   = reg_req_o ? wdata_q : '0;
   assign progbuf_req_o = (state_q == PROGBUF);
   assign data_wr_o     = data_wr_q;
   assign data_wdata_o  = data_wdata_q;
   assign cmd_wr_o      = cmd_wr_q;
   assign cmd_regno_o   = cmd_regno_q;
   assign cmderr_o      = cmderr_q;

endmodule

// File: tb/tb_riscv_dm_abstract_ctrl.sv
// Bench for riscv_dm_abstract_ctrl: directed scenarios plus randomized commands scored
// against an outcome-level model of the abstract command rules.
module tb_riscv_dm_abstract_ctrl;
   localparam int TMO = 1024;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        dmactive_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic [31:0] cmd_i = '0;
   logic [2:0]  cmderr_clr_i = '0;
   logic        data_access_i = 1'b0;
   logic        hart_halted_i = 1'b0;
   logic [63:0] data_i = '0;
   logic        reg_req_o, reg_we_o;
   logic [15:0] reg_addr_o;
   logic [63:0] reg_wdata_o;
   logic        reg_ack_i = 1'b0, reg_err_i = 1'b0;
   logic [63:0] reg_rdata_i = '0;
   logic        progbuf_req_o;
   logic        progbuf_done_i = 1'b0, progbuf_exc_i = 1'b0;
   logic        data_wr_o;
   logic [63:0] data_wdata_o;
   logic        cmd_wr_o;
   logic [15:0] cmd_regno_o;
   logic        busy_o;
   logic [2:0]  cmderr_o;

   riscv_dm_abstract_ctrl #(.XLEN(64), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .dmactive_i(dmactive_i), .cmd_valid_i(cmd_valid_i),
      .cmd_i(cmd_i), .cmderr_clr_i(cmderr_clr_i), .data_access_i(data_access_i),
      .hart_halted_i(hart_halted_i), .data_i(data_i), .reg_req_o(reg_req_o),
      .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
      .reg_ack_i(reg_ack_i), .reg_err_i(reg_err_i), .reg_rdata_i(reg_rdata_i),
      .progbuf_req_o(progbuf_req_o), .progbuf_done_i(progbuf_done_i),
      .progbuf_exc_i(progbuf_exc_i), .data_wr_o(data_wr_o), .data_wdata_o(data_wdata_o),
      .cmd_wr_o(cmd_wr_o), .cmd_regno_o(cmd_regno_o), .busy_o(busy_o), .cmderr_o(cmderr_o)
   );

   always #5 clk_i = ~clk_i;

   int tests = 0;
   int fails = 0;

   logic        ob_busy1, ob_req_seen, ob_we, ob_unstable, ob_pb_seen, ob_late_req, ob_hung;
   logic [15:0] ob_addr, ob_regno;
   logic [63:0] ob_wdata, ob_dwdata;
   int          ob_req_cyc, ob_dwr_cnt, ob_cwr_cnt, ob_busy_cyc;

   typedef struct packed {
      logic        accept;
      int          err;
      logic        req;
      logic        we;
      logic [15:0] addr;
      logic [63:0] wdata;
      int          dwr;
      logic [63:0] dval;
      int          cwr;
      logic [15:0] regno;
      logic        pb;
   } exp_t;

   // Outcome of one command, derived from the command-field rules and the hart's behaviour
   function automatic exp_t model(input logic [31:0] c, input logic halted, input logic [63:0] din,
                                  input int ack_lat, input logic ack_err, input logic [63:0] rdata,
                                  input int pb_lat, input logic pb_exc);
      exp_t e;
      logic [2:0] sz;
      logic [15:0] rn;
      e  = '0;
      sz = c[22:20];
      rn = c[15:0];
      if (c[31:24] != 8'd0 || (c[17] && !(sz == 3'd2 || sz == 3'd3)) || (c[17] && rn > 16'h101F)) begin
         e.err = 2;
         return e;
      end
      if (!halted) begin
         e.err = 4;
         return e;
      end
      e.accept = 1'b1;
      if (c[17]) begin
         e.req   = 1'b1;
         e.we    = c[16];
         e.addr  = rn;
         e.wdata = (sz == 3'd3) ? din : {32'h0, din[31:0]};
         if (ack_lat < 0 || ack_lat >= TMO) begin
            e.err = 7;
            return e;
         end
         if (ack_err) begin
            e.err = 3;
            return e;
         end
         if (!c[16]) begin
            e.dwr  = 1;
            e.dval = (sz == 3'd3) ? rdata : {32'h0, rdata[31:0]};
         end
         if (c[19]) begin
            e.cwr   = 1;
            e.regno = rn + 16'd1;
         end
      end
      if (c[18]) begin
         e.pb = 1'b1;
         if (pb_lat < 0 || pb_lat >= TMO) e.err = 7;
         else if (pb_exc) e.err = 3;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr_err();
      cmderr_clr_i = 3'd7;
      tick();
      cmderr_clr_i = 3'd0;
   endtask

   // Issues one COMMAND and plays the hart side until busy drops, recording observations
   task automatic serve(input logic [31:0] c, input int ack_lat, input logic ack_err,
                        input logic [63:0] rdata, input int pb_lat, input logic pb_exc,
                        input int inject_at);
      int pb_cyc;
      logic acked;
      cmd_i = c;
      cmd_valid_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0;
      ob_busy1 = busy_o;
      ob_req_seen = 0; ob_pb_seen = 0; ob_unstable = 0; ob_late_req = 0;
      ob_req_cyc = 0; ob_dwr_cnt = 0; ob_cwr_cnt = 0; ob_busy_cyc = 0;
      ob_addr = '0; ob_we = 0; ob_wdata = '0; ob_dwdata = '0; ob_regno = '0;
      pb_cyc = 0;
      acked = 0;
      while (busy_o && ob_busy_cyc < 3000) begin
         if (reg_req_o) begin
            if (acked) ob_late_req = 1'b1;
            ob_req_cyc++;
            if (!ob_req_seen) begin
               ob_req_seen = 1'b1;
               ob_addr = reg_addr_o; ob_we = reg_we_o; ob_wdata = reg_wdata_o;
            end else if (reg_addr_o !== ob_addr || reg_we_o !== ob_we || reg_wdata_o !== ob_wdata) begin
               ob_unstable = 1'b1;
            end
            if (ob_req_cyc == ack_lat + 1) begin
               reg_ack_i = 1'b1; reg_err_i = ack_err; reg_rdata_i = rdata; acked = 1'b1;
            end
         end
         if (progbuf_req_o) begin
            ob_pb_seen = 1'b1;
            pb_cyc++;
            if (pb_cyc == pb_lat + 1) begin
               progbuf_done_i = 1'b1; progbuf_exc_i = pb_exc;
            end
         end
         if (ob_busy_cyc == inject_at) cmd_valid_i = 1'b1;
         tick();
         ob_busy_cyc++;
         reg_ack_i = 1'b0; reg_err_i = 1'b0; reg_rdata_i = {$urandom, $urandom};
         progbuf_done_i = 1'b0; progbuf_exc_i = 1'b0; cmd_valid_i = 1'b0;
         if (data_wr_o) begin ob_dwr_cnt++; ob_dwdata = data_wdata_o; end
         if (cmd_wr_o) begin ob_cwr_cnt++; ob_regno = cmd_regno_o; end
      end
      ob_hung = busy_o;
   endtask

   task automatic test_reset();
      #1 rst_i = 1'b1;
      #2;
      tests++;
      if ({busy_o, reg_req_o, progbuf_req_o, data_wr_o, cmd_wr_o, reg_we_o} !== 6'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b required 000000", {busy_o, reg_req_o, progbuf_req_o, data_wr_o, cmd_wr_o, reg_we_o});
      end
      tests++;
      if ({cmderr_o, reg_addr_o, cmd_regno_o, reg_wdata_o, data_wdata_o} !== '0) begin
         fails++;
         $display("FAIL reset_data: cmderr=%0d addr=%h regno=%h required all zero", cmderr_o, reg_addr_o, cmd_regno_o);
      end
      tick(); tick();
      rst_i = 1'b0;
      tick();
      $display("[TB] reset checked");
   endtask

   task automatic test_read32();
      hart_halted_i = 1'b1;
      serve(32'h00221001, 2, 1'b0, 64'hFFFF_FFFF_1234_5678, -1, 1'b0, -1);
      tests++;
      if (ob_busy1 !== 1'b1 || ob_req_seen !== 1'b1) begin
         fails++; $display("FAIL read32_start: busy1=%b req=%b required 1 1", ob_busy1, ob_req_seen);
      end
      tests++;
      if (ob_addr !== 16'h1001 || ob_we !== 1'b0 || ob_unstable !== 1'b0) begin
         fails++; $display("FAIL read32_req: addr=%h we=%b unstable=%b required 1001 0 0", ob_addr, ob_we, ob_unstable);
      end
      tests++;
      if (ob_dwr_cnt != 1 || ob_dwdata !== 64'h0000_0000_1234_5678) begin
         fails++; $display("FAIL read32_data: pulses=%0d data=%h required 1 0000000012345678", ob_dwr_cnt, ob_dwdata);
      end
      tests++;
      if (busy_o !== 1'b0 || cmderr_o !== 3'd0 || ob_late_req !== 1'b0 || ob_cwr_cnt != 0) begin
         fails++; $display("FAIL read32_end: busy=%b cmderr=%0d late_req=%b cwr=%0d required 0 0 0 0", busy_o, cmderr_o, ob_late_req, ob_cwr_cnt);
      end
      $display("[TB] read32 addr=%h data=%h cmderr=%0d", ob_addr, ob_dwdata, cmderr_o);
   endtask

   task automatic test_write_postinc_postexec();
      logic [63:0] d;
      d = {$urandom, $urandom};
      data_i = d;
      // 64-bit write of x8 with postincrement and postexec
      serve(32'h003F1008, 1, 1'b0, '0, 3, 1'b0, -1);
      tests++;
      if (ob_we !== 1'b1 || ob_wdata !== d || ob_addr !== 16'h1008) begin
         fails++; $display("FAIL write64_req: we=%b wdata=%h addr=%h required 1 %h 1008", ob_we, ob_wdata, ob_addr, d);
      end
      tests++;
      if (ob_cwr_cnt != 1 || ob_regno !== 16'h1009) begin
         fails++; $display("FAIL write64_postinc: pulses=%0d regno=%h required 1 1009", ob_cwr_cnt, ob_regno);
      end
      tests++;
      if (ob_pb_seen !== 1'b1 || ob_dwr_cnt != 0 || cmderr_o !== 3'd0 || busy_o !== 1'b0) begin
         fails++; $display("FAIL write64_end: pb=%b dwr=%0d cmderr=%0d busy=%b required 1 0 0 0", ob_pb_seen, ob_dwr_cnt, cmderr_o, busy_o);
      end
      $display("[TB] write64 regno_next=%h cmderr=%0d", ob_regno, cmderr_o);
   endtask

   task automatic test_bad_cmd();
      logic [31:0] cmds [4];
      logic [2:0]  errs [4];
      cmds = '{32'h01221001, 32'h00421001, 32'h00221020, 32'h0022101F};
      errs = '{3'd2, 3'd2, 3'd2, 3'd0};
      for (int i = 0; i < 4; i++) begin
         serve(cmds[i], 0, 1'b0, '0, -1, 1'b0, -1);
         tests++;
         if (cmderr_o !== errs[i] || ob_req_seen !== (errs[i] == 3'd0)) begin
            fails++; $display("FAIL bad_cmd[%0d]: cmderr=%0d req=%b required %0d", i, cmderr_o, ob_req_seen, errs[i]);
         end
         $display("[TB] cmd %h cmderr=%0d", cmds[i], cmderr_o);
         if (i == 0) begin
            serve(32'h00221001, 0, 1'b0, '0, -1, 1'b0, -1);
            tests++;
            if (ob_busy1 !== 1'b0 || cmderr_o !== 3'd2) begin
               fails++; $display("FAIL ignored_cmd: busy=%b cmderr=%0d required 0 2", ob_busy1, cmderr_o);
            end
         end
         clr_err();
         tests++;
         if (cmderr_o !== 3'd0) begin
            fails++; $display("FAIL cmderr_clear: cmderr=%0d required 0", cmderr_o);
         end
      end
   endtask

   task automatic test_not_halted_and_busy();
      hart_halted_i = 1'b0;
      serve(32'h00221001, 0, 1'b0, '0, -1, 1'b0, -1);
      tests++;
      if (cmderr_o !== 3'd4 || ob_busy1 !== 1'b0) begin
         fails++; $display("FAIL not_halted: cmderr=%0d busy=%b required 4 0", cmderr_o, ob_busy1);
      end
      clr_err();
      hart_halted_i = 1'b1;
      serve(32'h00221003, 4, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD, -1, 1'b0, 1);
      tests++;
      if (cmderr_o !== 3'd1 || ob_dwr_cnt != 1 || ob_dwdata !== 64'h0000_0000_CCCC_DDDD) begin
         fails++; $display("FAIL busy_cmd: cmderr=%0d dwr=%0d data=%h required 1 1 00000000ccccdddd", cmderr_o, ob_dwr_cnt, ob_dwdata);
      end
      $display("[TB] not_halted/busy cmderr=%0d", cmderr_o);
      clr_err();
   endtask

   task automatic test_reg_err();
      serve(32'h003E1002, 1, 1'b1, 64'h1, 2, 1'b0, -1);
      tests++;
      if (cmderr_o !== 3'd3 || ob_dwr_cnt != 0 || ob_cwr_cnt != 0 || ob_pb_seen !== 1'b0 || busy_o !== 1'b0) begin
         fails++; $display("FAIL reg_err: cmderr=%0d dwr=%0d cwr=%0d pb=%b required 3 0 0 0", cmderr_o, ob_dwr_cnt, ob_cwr_cnt, ob_pb_seen);
      end
      clr_err();
      serve(32'h00040000, 0, 1'b0, '0, 2, 1'b1, -1);
      tests++;
      if (cmderr_o !== 3'd3 || ob_pb_seen !== 1'b1 || ob_req_seen !== 1'b0) begin
         fails++; $display("FAIL pb_exc: cmderr=%0d pb=%b req=%b required 3 1 0", cmderr_o, ob_pb_seen, ob_req_seen);
      end
      $display("[TB] reg_err / pb_exc cmderr=%0d", cmderr_o);
      clr_err();
   endtask

   task automatic test_timeout();
      serve(32'h00221005, -1, 1'b0, '0, -1, 1'b0, -1);
      tests++;
      if (ob_req_cyc != TMO || cmderr_o !== 3'd7 || busy_o !== 1'b0 || ob_dwr_cnt != 0) begin
         fails++; $display("FAIL timeout: req_cycles=%0d cmderr=%0d busy=%b required %0d 7 0", ob_req_cyc, cmderr_o, busy_o, TMO);
      end
      reg_ack_i = 1'b1;
      tick();
      reg_ack_i = 1'b0;
      tick();
      tests++;
      if (data_wr_o !== 1'b0 || cmderr_o !== 3'd7 || busy_o !== 1'b0) begin
         fails++; $display("FAIL late_ack: data_wr=%b cmderr=%0d busy=%b required 0 7 0", data_wr_o, cmderr_o, busy_o);
      end
      clr_err();
      serve(32'h00221005, TMO - 1, 1'b0, 64'h0000_0000_0BAD_F00D, -1, 1'b0, -1);
      tests++;
      if (cmderr_o !== 3'd0 || ob_dwr_cnt != 1 || ob_req_cyc != TMO) begin
         fails++; $display("FAIL ack_at_expiry: cmderr=%0d dwr=%0d req_cycles=%0d required 0 1 %0d", cmderr_o, ob_dwr_cnt, ob_req_cyc, TMO);
      end
      serve(32'h00040000, 0, 1'b0, '0, -1, 1'b0, -1);
      tests++;
      if (cmderr_o !== 3'd7 || ob_pb_seen !== 1'b1 || busy_o !== 1'b0) begin
         fails++; $display("FAIL pb_timeout: cmderr=%0d pb=%b busy=%b required 7 1 0", cmderr_o, ob_pb_seen, busy_o);
      end
      $display("[TB] timeout paths done cmderr=%0d", cmderr_o);
      clr_err();
   endtask

   task automatic test_noop();
      serve(32'h00000000, 0, 1'b0, '0, -1, 1'b0, -1);
      tests++;
      if (ob_busy1 !== 1'b1 || ob_busy_cyc != 1 || ob_req_seen !== 1'b0 || ob_pb_seen !== 1'b0 || cmderr_o !== 3'd0) begin
         fails++; $display("FAIL noop: busy1=%b busy_cycles=%0d req=%b pb=%b cmderr=%0d required 1 1 0 0 0", ob_busy1, ob_busy_cyc, ob_req_seen, ob_pb_seen, cmderr_o);
      end
      $display("[TB] noop busy_cycles=%0d", ob_busy_cyc);
   endtask

   task automatic test_dmactive();
      cmd_i = 32'h00221001;
      cmd_valid_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0;
      data_access_i = 1'b1;
      tick();
      data_access_i = 1'b0;
      tests++;
      if (cmderr_o !== 3'd1 || reg_req_o !== 1'b1) begin
         fails++; $display("FAIL data_access_busy: cmderr=%0d req=%b required 1 1", cmderr_o, reg_req_o);
      end
      dmactive_i = 1'b0;
      tick();
      tests++;
      if (busy_o !== 1'b0 || reg_req_o !== 1'b0 || cmderr_o !== 3'd0) begin
         fails++; $display("FAIL dmactive_clear: busy=%b req=%b cmderr=%0d required 0 0 0", busy_o, reg_req_o, cmderr_o);
      end
      dmactive_i = 1'b1;
      tick();
      $display("[TB] dmactive clear busy=%b cmderr=%0d", busy_o, cmderr_o);
   endtask

   task automatic test_async_reset();
      cmd_i = 32'h00040000;
      cmd_valid_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0;
      tick();
      tests++;
      if (progbuf_req_o !== 1'b1) begin
         fails++; $display("FAIL pb_before_reset: progbuf_req=%b required 1", progbuf_req_o);
      end
      #2 rst_i = 1'b1;
      #1;
      tests++;
      if ({busy_o, progbuf_req_o, reg_req_o, data_wr_o, cmd_wr_o, cmderr_o} !== 8'b0) begin
         fails++; $display("FAIL async_reset: busy=%b pb=%b req=%b cmderr=%0d required all zero", busy_o, progbuf_req_o, reg_req_o, cmderr_o);
      end
      tick();
      rst_i = 1'b0;
      tick();
      $display("[TB] async reset mid-progbuf busy=%b", busy_o);
   endtask

   task automatic test_random();
      for (int it = 0; it < 60; it++) begin
         logic [31:0] c;
         logic [2:0]  sz;
         logic [15:0] rn;
         logic [7:0]  ct;
         logic        halted, aerr, pexc;
         int          alat, plat;
         logic [63:0] rd, din;
         exp_t        e;
         sz  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 3));
         rn  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 'h101F));
         ct  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         c   = {ct, 1'b0, sz, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom), rn};
         halted = ($urandom_range(0, 4) != 0);
         alat = $urandom_range(0, 5);
         aerr = ($urandom_range(0, 6) == 0);
         plat = $urandom_range(0, 5);
         pexc = ($urandom_range(0, 6) == 0);
         rd   = {$urandom, $urandom};
         din  = {$urandom, $urandom};
         hart_halted_i = halted;
         data_i = din;
         e = model(c, halted, din, alat, aerr, rd, plat, pexc);
         serve(c, alat, aerr, rd, plat, pexc, -1);
         tests++;
         if (cmderr_o !== 3'(e.err) || ob_busy1 !== e.accept || ob_hung !== 1'b0) begin
            fails++; $display("FAIL rnd[%0d] status: cmd=%h cmderr=%0d busy1=%b hung=%b required %0d %b 0", it, c, cmderr_o, ob_busy1, ob_hung, e.err, e.accept);
         end
         tests++;
         if (ob_req_seen !== e.req || (e.req && (ob_addr !== e.addr || ob_we !== e.we || ob_wdata !== e.wdata || ob_unstable))) begin
            fails++; $display("FAIL rnd[%0d] request: cmd=%h req=%b addr=%h we=%b wdata=%h required %b %h %b %h", it, c, ob_req_seen, ob_addr, ob_we, ob_wdata, e.req, e.addr, e.we, e.wdata);
         end
         tests++;
         if (ob_dwr_cnt != e.dwr || (e.dwr == 1 && ob_dwdata !== e.dval)) begin
            fails++; $display("FAIL rnd[%0d] data_wr: cmd=%h pulses=%0d data=%h required %0d %h", it, c, ob_dwr_cnt, ob_dwdata, e.dwr, e.dval);
         end
         tests++;
         if (ob_cwr_cnt != e.cwr || (e.cwr == 1 && ob_regno !== e.regno) || ob_pb_seen !== e.pb || ob_late_req) begin
            fails++; $display("FAIL rnd[%0d] post: cmd=%h cwr=%0d regno=%h pb=%b late=%b required %0d %h %b 0", it, c, ob_cwr_cnt, ob_regno, ob_pb_seen, ob_late_req, e.cwr, e.regno, e.pb);
         end
         $display("[TB] rnd %0d cmd=%h halted=%b cmderr=%0d", it, c, halted, cmderr_o);
         clr_err();
      end
   endtask

   initial begin
      test_reset();
      test_read32();
      test_write_postinc_postexec();
      test_bad_cmd();
      test_not_halted_and_busy();
      test_reg_err();
      test_timeout();
      test_noop();
      test_dmactive();
      test_async_reset();
      hart_halted_i = 1'b1;
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
